// File: rtl/sort_pkg.sv
// Shared state encoding and fixed geometry for the 16-word selection-exchange sort.
package sort_pkg;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      LOAD_A   = 4'd1,
      LOAD_B   = 4'd2,
      CMP      = 4'd3,
      SWAP_I   = 4'd4,
      SWAP_J   = 4'd5,
      RELOAD_A = 4'd6,
      NEXT_J   = 4'd7,
      NEXT_I   = 4'd8,
      DONE     = 4'd9
   } sort_state_t;

   localparam int SORT_K          = 16;
   localparam int SORT_CYC_NOSWAP = 391;
   localparam int SORT_SWAP_CYC   = 3;

endpackage

// File: rtl/sort_controller.sv
// Moore control FSM sequencing the in-place RAM sort datapath (ascending, 16 words).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; holds counter i at 0
// LOAD_A   | A <= RAM[i], j <= i+1
// LOAD_B   | B <= RAM[j]
// CMP      | decide on swap from AgtB
// SWAP_I   | RAM[i] <= B
// SWAP_J   | RAM[j] <= A (old RAM[i])
// RELOAD_A | A <= RAM[i] (new minimum candidate)
// NEXT_J   | advance j or finish inner pass
// NEXT_I   | advance i or finish sort
// DONE     | sort complete; waits for start to drop
module sort_controller
   import sort_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic zi,
   input  logic zj,
   input  logic AgtB,
   output logic Li,
   output logic Ei,
   output logic Lj,
   output logic Ej,
   output logic EA,
   output logic EB,
   output logic Csel,
   output logic Bout,
   output logic Wr,
   output logic busy,
   output logic done
);

   sort_state_t state_q, state_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE:     state_d = start ? LOAD_A : IDLE;
         LOAD_A:   state_d = LOAD_B;
         LOAD_B:   state_d = CMP;
         CMP:      state_d = AgtB ? SWAP_I : NEXT_J;
         SWAP_I:   state_d = SWAP_J;
         SWAP_J:   state_d = RELOAD_A;
         RELOAD_A: state_d = NEXT_J;
         NEXT_J:   state_d = zj ? NEXT_I : LOAD_B;
         NEXT_I:   state_d = zi ? DONE : LOAD_A;
         DONE:     state_d = start ? DONE : IDLE;
         default:  state_d = IDLE;
      endcase
      // Dropping start aborts from any working state; RAM is left as-is.
      if (!start && state_q != IDLE && state_q != DONE) state_d = IDLE;
   end

   always_comb begin
      Li   = 1'b0;
      Ei   = 1'b0;
      Lj   = 1'b0;
      Ej   = 1'b0;
      EA   = 1'b0;
      EB   = 1'b0;
      Csel = 1'b0;
      Bout = 1'b0;
      Wr   = 1'b0;
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         IDLE:     Li = 1'b1;
         LOAD_A:   begin busy = 1'b1; EA = 1'b1; Lj = 1'b1; end
         LOAD_B:   begin busy = 1'b1; EB = 1'b1; Csel = 1'b1; end
         CMP:      busy = 1'b1;
         SWAP_I:   begin busy = 1'b1; Bout = 1'b1; Wr = 1'b1; end
         SWAP_J:   begin busy = 1'b1; Csel = 1'b1; Wr = 1'b1; end
         RELOAD_A: begin busy = 1'b1; EA = 1'b1; end
         // Increment strobes are suppressed at the terminal count so the counters never wrap.
         NEXT_J:   begin busy = 1'b1; Ej = ~zj; end
         NEXT_I:   begin busy = 1'b1; Ei = ~zi; end
         DONE:     done = 1'b1;
         default:  ;
      endcase
   end

endmodule

// File: tb/tb_sort_controller.sv
// Directed bench: sort_controller driving a behavioural copy of the sort datapath.
module tb_sort_controller;
   import sort_pkg::*;

   typedef logic [7:0] mem_t [SORT_K];

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic zi, zj, AgtB;
   logic Li, Ei, Lj, Ej, EA, EB, Csel, Bout, Wr, busy, done;

   int total = 0;
   int bad = 0;

   sort_controller dut (
      .clk(clk), .rst(rst), .start(start), .zi(zi), .zj(zj), .AgtB(AgtB),
      .Li(Li), .Ei(Ei), .Lj(Lj), .Ej(Ej), .EA(EA), .EB(EB), .Csel(Csel),
      .Bout(Bout), .Wr(Wr), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // datapath model
   mem_t ram;
   mem_t pre_mem;
   logic do_load = 1'b0;
   logic [3:0] mi = 4'd0;
   logic [3:0] mj = 4'd0;
   logic [7:0] ma = 8'd0;
   logic [7:0] mb = 8'd0;
   logic [3:0] addr;

   assign addr = Csel ? mj : mi;
   assign zi   = (mi == 4'd14);
   assign zj   = (mj == 4'd15);
   assign AgtB = (ma > mb);

   always @(posedge clk) begin
      if (do_load) ram <= pre_mem;
      else if (Wr) ram[addr] <= Bout ? mb : ma;
      if (Li) mi <= 4'd0;
      else if (Ei) mi <= mi + 4'd1;
      if (Lj) mj <= mi + 4'd1;
      else if (Ej) mj <= mj + 4'd1;
      if (EA) ma <= ram[addr];
      if (EB) mb <= ram[addr];
   end

   localparam logic [10:0] RST_OUTS = 11'b100_0000_0000;
   wire [10:0] outs = {Li, Ei, Lj, Ej, EA, EB, Csel, Bout, Wr, busy, done};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   function automatic int ref_swaps(input mem_t m);
      int n = 0;
      logic [7:0] a, t;
      for (int i = 0; i < SORT_K - 1; i++) begin
         a = m[i];
         for (int j = i + 1; j < SORT_K; j++) begin
            if (a > m[j]) begin
               t = m[i]; m[i] = m[j]; m[j] = t;
               a = m[i];
               n++;
            end
         end
      end
      return n;
   endfunction

   task automatic load_mem(input mem_t m);
      @(negedge clk);
      pre_mem = m;
      do_load = 1'b1;
      @(negedge clk);
      do_load = 1'b0;
   endtask

   task automatic run_sort(input string tag, input int exp_cyc, output int wr_cnt);
      int cyc = 0;
      int pair_err = 0;
      int eq_swap = 0;
      logic want_j = 1'b0;
      wr_cnt = 0;
      @(negedge clk);
      start = 1'b1;
      while (!done && cyc < 3000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (Wr) wr_cnt++;
         if (want_j) begin
            if (!(Wr && Csel && !Bout)) pair_err++;
            want_j = 1'b0;
         end else if (Wr && !Csel && Bout) begin
            want_j = 1'b1;
            if (!(ma > mb)) eq_swap++;
         end else if (Wr) pair_err++;
      end
      chk({tag, "_cycles"}, cyc, exp_cyc);
      chk({tag, "_wr_pairs"}, pair_err, 0);
      chk({tag, "_swap_only_gt"}, eq_swap, 0);
      chk({tag, "_wr_count"}, wr_cnt, 2 * ((exp_cyc - SORT_CYC_NOSWAP) / SORT_SWAP_CYC));
      @(negedge clk);
      chk({tag, "_done_held"}, outs, 11'b000_0000_0001);
      start = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, "_back_idle"}, outs, RST_OUTS);
   endtask

   initial begin
      mem_t m, exp_m;
      int w, cyc, nbad;

      // reset and idle
      #2;
      chk("reset_outs", outs, RST_OUTS);
      @(negedge clk);
      rst = 1'b1;
      nbad = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (outs !== RST_OUTS) nbad++;
      end
      chk("idle_20cyc", nbad, 0);

      // already sorted
      for (int k = 0; k < SORT_K; k++) m[k] = 8'(k);
      load_mem(m);
      run_sort("sorted", SORT_CYC_NOSWAP, w);
      nbad = 0;
      for (int k = 0; k < SORT_K; k++) if (ram[k] !== 8'(k)) nbad++;
      chk("sorted_ram_unchanged", nbad, 0);

      // reverse order
      for (int k = 0; k < SORT_K; k++) m[k] = 8'(15 - k);
      load_mem(m);
      run_sort("reverse", SORT_CYC_NOSWAP + SORT_SWAP_CYC * ref_swaps(m), w);
      for (int k = 0; k < SORT_K; k++) chk($sformatf("reverse_ram%0d", k), ram[k], 8'(k));

      // duplicates
      m = '{8'd5, 8'd5, 8'd3, 8'd3, 8'd7, 8'd7, 8'd1, 8'd1,
            8'd8, 8'd8, 8'd2, 8'd2, 8'd0, 8'd0, 8'd9, 8'd9};
      exp_m = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3,
                8'd5, 8'd5, 8'd7, 8'd7, 8'd8, 8'd8, 8'd9, 8'd9};
      load_mem(m);
      run_sort("dups", SORT_CYC_NOSWAP + SORT_SWAP_CYC * ref_swaps(m), w);
      nbad = 0;
      for (int k = 0; k < SORT_K; k++) if (ram[k] !== exp_m[k]) nbad++;
      chk("dups_ram_sorted", nbad, 0);

      // abort during SWAP_J of outer pass i=3
      for (int k = 0; k < SORT_K; k++) m[k] = 8'(15 - k);
      load_mem(m);
      @(negedge clk);
      start = 1'b1;
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!(Wr && Csel && mi == 4'd3) && cyc < 3000);
      chk("abort_found_swapj", (cyc < 3000), 1);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_wr_off", Wr, 1'b0);
      chk("abort_busy_off", busy, 1'b0);
      chk("abort_idle_outs", outs, RST_OUTS);
      nbad = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         if (Wr) nbad++;
      end
      chk("abort_no_wr", nbad, 0);
      m = ram;
      run_sort("restart", SORT_CYC_NOSWAP + SORT_SWAP_CYC * ref_swaps(m), w);
      for (int k = 0; k < SORT_K; k++) chk($sformatf("restart_ram%0d", k), ram[k], 8'(k));

      // async reset while in CMP
      m = '{8'd5, 8'd5, 8'd3, 8'd3, 8'd7, 8'd7, 8'd1, 8'd1,
            8'd8, 8'd8, 8'd2, 8'd2, 8'd0, 8'd0, 8'd9, 8'd9};
      load_mem(m);
      @(negedge clk);
      start = 1'b1;
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!EB && cyc < 3000);
      chk("arst_found_loadb", (cyc < 3000), 1);
      @(posedge clk);
      #3;
      chk("arst_in_cmp", outs, 11'b000_0000_0010);
      rst = 1'b0;
      #1;
      chk("arst_outs_now", outs, RST_OUTS);
      chk("arst_done_low", done, 1'b0);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("arst_release_idle", outs, RST_OUTS);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sort_controller.md
Name: sort_controller

Overview:
- Control FSM for the in-place RAM sort engine. It sits directly upstream of the sort datapath.
- It drives the datapath strobes (Li, Ei, Lj, Ej, EA, EB, Csel, Bout, Wr) and consumes its status flags (zi, zj, AgtB).
- It runs a selection-exchange sort over 16 words in ascending order. It reports completion with done/busy.
- The top level ties the same start to both this block and the datapath.

Parameters:
- None. List length (16) and counter limits are fixed by the datapath; the zi/zj flags encode them.

Ports:
- clk    input   1  system clock, rising edge
- rst    input   1  reset; one clock, asynchronous, active-low (rst=0 resets)
- start  input   1  level-held sort request; must stay 1 for the whole sort
- zi     input   1  datapath flag: counter i == 14
- zj     input   1  datapath flag: counter j == 15
- AgtB   input   1  datapath flag: regA > regB (unsigned)
- Li     output  1  load counter i with 0
- Ei     output  1  increment counter i
- Lj     output  1  load counter j with i+1
- Ej     output  1  increment counter j
- EA     output  1  regA <= RAM[addr]
- EB     output  1  regB <= RAM[addr]
- Csel   output  1  address select: 0 = i, 1 = j
- Bout   output  1  write-data select: 0 = regA, 1 = regB
- Wr     output  1  RAM write enable
- busy   output  1  1 in every state except IDLE and DONE
- done   output  1  1 only in DONE

Behaviour:
- Moore machine. Every output is decoded from the state register only, with no input-to-output combinational paths. The state register resets asynchronously to IDLE.
- Reset values: state = IDLE, so Li = 1 and all other outputs are 0.
- RAM read is combinational. A register enabled in state X captures RAM[addr(X)] at the edge that leaves X. A RAM write in state X is visible from the next cycle.
- States and transitions (outputs not listed are 0):
  - IDLE: Li=1. start=1 -> LOAD_A; otherwise stay.
  - LOAD_A: Csel=0, EA=1, Lj=1 -> LOAD_B.
  - LOAD_B: Csel=1, EB=1 -> CMP.
  - CMP: no strobes. AgtB=1 -> SWAP_I; else -> NEXT_J.
  - SWAP_I: Csel=0, Bout=1, Wr=1 (RAM[i] <= B) -> SWAP_J.
  - SWAP_J: Csel=1, Bout=0, Wr=1 (RAM[j] <= old A) -> RELOAD_A.
  - RELOAD_A: Csel=0, EA=1 (A <= new RAM[i]) -> NEXT_J.
  - NEXT_J: zj=1 -> NEXT_I; else Ej=1 -> LOAD_B.
  - NEXT_I: zi=1 -> DONE; else Ei=1 -> LOAD_A.
  - DONE: done=1. start=0 -> IDLE; else stay.
- Flag sampling:
  - AgtB is used only in CMP.
  - zj is used only in NEXT_J. Ej is not asserted when zj=1, so there is no wrap.
  - zi is used only in NEXT_I. Ei is not asserted when zi=1.
- Equal keys: AgtB=0, so no swap (stable w.r.t. equal pairs).
- Latency, with no swaps: done rises 391 clock edges after the first edge that samples start=1 in IDLE. Each swap adds 3 cycles.
- Abort: start=0 in any busy state -> IDLE on the next edge. No further Wr is issued and RAM contents are left partially sorted. A new start restarts from i=0.
- Asynchronous reset mid-sort: immediate return to IDLE outputs. A Wr in flight is deasserted at once.
- Unused state encodings -> IDLE.
- done stays high while start stays high; done does not re-trigger a sort until start has been 0 for at least one cycle.

Decomposition:
- sort_pkg holds the following shared items:
  - typedef enum logic [3:0] sort_state_t: IDLE, LOAD_A, LOAD_B, CMP, SWAP_I, SWAP_J, RELOAD_A, NEXT_J, NEXT_I, DONE.
  - localparams SORT_K=16, SORT_CYC_NOSWAP=391, SORT_SWAP_CYC=3.
- No sub-module. Next-state logic and output decode live in two always blocks in one module.
- Top-level sort_top instantiates sort_controller and datapath.

Test Plan:
- Reset then idle: rst=0 with start=0 -> Li=1, all other strobes 0, busy=0, done=0. Release reset with start=0 for 20 cycles -> state stays IDLE.
- Sorted input: RAM preloaded 0..15, start=1 held -> no Wr pulse ever; done rises exactly 391 edges after start; RAM unchanged.
- Reverse input: RAM preloaded 15..0, start held -> RAM reads 0..15 ascending; cycle count = 391 + 3*(swaps counted by reference model); every Wr pulse occurs in SWAP_I/SWAP_J pairs.
- Duplicates: RAM {5,5,3,3,...,9} -> ascending result; CMP with A==B never enters SWAP_I.
- Abort: drop start during SWAP_J of outer pass i=3 -> Wr is 0 from the next edge, busy=0, state IDLE; restart completes with a sorted RAM.
- Async reset mid-sort: assert rst low between clock edges in CMP -> outputs return to reset values without waiting for a clk edge; done=0.
